// File: rtl/cpu_pkg.sv
// Shared core definitions used by the register-file dump reader:
// FSM state encoding, frame constants and the word-to-byte selector.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_FETCH,
    S_SEND,
    S_CSUM,
    S_DONE
  } dump_state_t;

  localparam logic [7:0] DUMP_HEADER = 8'hA5;
  localparam int         NUM_REGS    = 32;
  localparam int         DUMP_BYTES  = 130;

  // Big-endian byte select: index 0 is the most significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/regfile_dump_if.sv
// Valid/ready byte stream from the dump reader to the UART transmitter.
interface regfile_dump_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/regfile_dump.sv
// Walks x0..x31 through a dedicated read port and streams a framed packet:
// header byte, 128 big-endian data bytes, XOR checksum of the data bytes.
module regfile_dump
  import cpu_pkg::*;
#(
  parameter logic [7:0] HEADER = DUMP_HEADER
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        busy,
  output logic        done,
  regfile_dump_if.master tx
);

  localparam logic [4:0] LAST_REG = 5'(NUM_REGS - 1);

  dump_state_t state;
  logic [4:0]  reg_cnt;
  logic [1:0]  byte_idx;
  logic [31:0] word;
  logic [7:0]  csum;
  logic [7:0]  cur_byte;

  // NOTE: every branch of a combinational block must assign its outputs;
  // the default first line keeps synthesis from inferring a latch.
  always_comb begin
    cur_byte = 8'h00;
    case (state)
      S_HEADER: cur_byte = HEADER;
      S_SEND:   cur_byte = word_byte(word, byte_idx);
      S_CSUM:   cur_byte = csum;
      default:  cur_byte = 8'h00;
    endcase
  end

  // Outputs decode registered state only; nothing from tx_ready or rd_data
  // reaches an output combinationally.
  assign tx.tx_data  = cur_byte;
  assign tx.tx_valid = (state == S_HEADER) || (state == S_SEND) || (state == S_CSUM);
  assign busy        = (state == S_HEADER) || (state == S_FETCH) ||
                       (state == S_SEND)   || (state == S_CSUM);
  assign done        = (state == S_DONE);
  assign rd_addr     = reg_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      reg_cnt  <= '0;
      byte_idx <= '0;
      csum     <= '0;
      word     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_HEADER;
            reg_cnt <= '0;
            csum    <= '0;
          end
        end
        S_HEADER: begin
          if (tx.tx_ready) state <= S_FETCH;
        end
        S_FETCH: begin
          word     <= rd_data;
          byte_idx <= '0;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (tx.tx_ready) begin
            csum <= csum ^ cur_byte;
            if (byte_idx == 2'd3) begin
              // Termination is an explicit compare; the counter never wraps.
              if (reg_cnt == LAST_REG) begin
                state <= S_CSUM;
              end else begin
                reg_cnt <= reg_cnt + 5'd1;
                state   <= S_FETCH;
              end
            end else begin
              byte_idx <= byte_idx + 2'd1;
            end
          end
        end
        S_CSUM: begin
          if (tx.tx_ready) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/regfile_dump.md
# regfile_dump

Debug reader for the RV32 register file. On a start pulse it walks x0..x31 through a dedicated combinational read port, serializes each 32-bit word into bytes, and streams a framed packet (header, 128 data bytes, XOR checksum) on a valid/ready byte interface. The downstream consumer is the board UART transmitter. It sits beside the core's register file and never writes it.

## Interface
- `HEADER`, default 8'hA5: first byte of every packet.
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high; sampled on posedge `clk`.
- `start`  in  1  request a dump; sampled only in IDLE.
- `rd_addr`  out  5  register-file read address; drives the third read port.
- `rd_data`  in  32  combinational read data for `rd_addr`, valid the same cycle.
- `tx_data`  out  8  byte to transmit.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  consumer accepts the byte; a transfer occurs on a posedge with `tx_valid && tx_ready`.
- `busy`  out  1  dump in progress.
- `done`  out  1  one-cycle pulse after the checksum byte transfers.

## Operation
- FSM states: IDLE, HEADER, FETCH, SEND, CSUM, DONE.
- IDLE: `start` high moves to HEADER; address counter is cleared to 0; checksum is cleared to 0.
- HEADER: `tx_valid`=1, `tx_data`=`HEADER`. On transfer, moves to FETCH.
- FETCH: `tx_valid`=0 and `rd_addr`=counter. `rd_data` latches into the word register at the edge. Byte index is cleared to 0. Moves to SEND.
- SEND: `tx_valid`=1, and bytes go out big-endian: index 0 is word[31:24], index 3 is word[7:0].
  - Each transfer XORs the byte into the checksum.
  - After index 3 transfers: counter=31 moves to CSUM; otherwise the counter increments and the FSM returns to FETCH.
- CSUM: `tx_valid`=1, `tx_data`=checksum, which is the XOR of all 128 data bytes (header excluded). On transfer, moves to DONE.
- DONE: `done`=1 for exactly one cycle, `busy`=0, then IDLE.
- `busy`=1 in HEADER, FETCH, SEND and CSUM; 0 in IDLE and DONE.
- `start` is ignored outside IDLE and is not queued.
- x0 is read like any other register; the port returns 0.
- No cross-word atomicity: each word is the register value at its own FETCH edge. A core write to a register after its FETCH is not reflected.
- The 5-bit counter never wraps. Termination is decided by counter==31 plus index 3, not by overflow.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0, `rd_addr`=0, `busy`=0, `done`=0, state=IDLE, checksum=0.
- `reset` mid-dump aborts at the next edge: all outputs take reset values and no partial frame resumes.
- `start` high at edge E0 puts the FSM in HEADER during cycle E0→E1.
- With `tx_ready` held high, a frame is 1 header cycle + 32×(1 FETCH + 4 SEND) + 1 CSUM = 162 cycles of `busy`. `done` is high in cycle 163.
- Backpressure: while `tx_valid`=1 and `tx_ready`=0, `tx_data` holds stable and the state is unchanged. `tx_valid` never drops without a transfer, except on reset.
- All outputs are registered or decoded from registered state. `tx_data` depends only on registered word, index and state; there is no combinational path from `tx_ready` or `rd_data` to any output.

## Structure
- The shared core package `cpu_pkg` holds:
  - the state enum `dump_state_t`;
  - `DUMP_HEADER` = 8'hA5;
  - `NUM_REGS` = 32;
  - `DUMP_BYTES` = 130.
- No sub-module is needed. The byte mux and the XOR accumulator stay inline.
- The register file exposes a third combinational read port (address `a4`, data `read_data_3`) wired to `rd_addr`/`rd_data`.

## Test plan
- All registers 0, `tx_ready`=1, pulse `start` → bytes A5, then 128×00, then checksum 00. `busy` is high 162 cycles and `done` pulses once in cycle 163.
- Only x1=0x12345678 → bytes A5, 00 00 00 00, 12 34 56 78, 120×00, then checksum 0x08.
- xN=N×0x01010101 for N=0..31, with random `tx_ready` (50% duty) → the byte sequence matches the model exactly. `tx_data` is stable across every stalled valid cycle.
- `start` re-pulsed at cycles 5 and 100 of a dump → a single frame only, with no second header until after `done`.
- `reset` asserted during the SEND of x10 → the next cycle shows `tx_valid`=0, `busy`=0 and `rd_addr`=0. A fresh `start` produces a complete correct frame starting with A5.
- x5 rewritten by a core write one cycle after its FETCH → the old value is transmitted. The same write one cycle before its FETCH → the new value is transmitted.
